// File: rtl/pdl_ptr_ctl_if.sv
// Purpose: bundles the decode-stage strobes, OB bus and PDL address outputs
//          exchanged between the decode stage and pdl_ptr_ctl.
// Ports (signals):
//   decode -> ctl : state_write, nop, destpdlp, destpdlx, destpdltop, destpdl_p,
//                   destpdl_x, srcpdltop, srcpdlpop, ob[31:0]
//   ctl -> decode : pdlptr, pdlidx, pdlra, pdlwa, pdlwe, pdlbypass, pdlovf, pdlunf
// master = decode side, slave = pdl_ptr_ctl.
interface pdl_ptr_ctl_if #(
   parameter int unsigned PDL_AW = 10
);
   logic              state_write;
   logic              nop;
   logic              destpdlp;
   logic              destpdlx;
   logic              destpdltop;
   logic              destpdl_p;
   logic              destpdl_x;
   logic              srcpdltop;
   logic              srcpdlpop;
   logic [31:0]       ob;
   logic [PDL_AW-1:0] pdlptr;
   logic [PDL_AW-1:0] pdlidx;
   logic [PDL_AW-1:0] pdlra;
   logic [PDL_AW-1:0] pdlwa;
   logic              pdlwe;
   logic              pdlbypass;
   logic              pdlovf;
   logic              pdlunf;

   modport master (
      output state_write, nop, destpdlp, destpdlx, destpdltop, destpdl_p,
             destpdl_x, srcpdltop, srcpdlpop, ob,
      input  pdlptr, pdlidx, pdlra, pdlwa, pdlwe, pdlbypass, pdlovf, pdlunf
   );

   modport slave (
      input  state_write, nop, destpdlp, destpdlx, destpdltop, destpdl_p,
             destpdl_x, srcpdltop, srcpdlpop, ob,
      output pdlptr, pdlidx, pdlra, pdlwa, pdlwe, pdlbypass, pdlovf, pdlunf
   );
endinterface

// File: rtl/pdl_ptr_ctl.sv
// Purpose: PDL pointer/index registers plus PDL RAM read/write address and
//          write-strobe sequencing.
// Ports:
//   clk      : system clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : pdl_ptr_ctl_if.slave (strobes/OB in; pdlptr, pdlidx, pdlra (comb),
//              pdlwa, pdlwe, pdlbypass (comb), pdlovf, pdlunf out)
// PDL_AW must match the interface instance's PDL_AW.
module pdl_ptr_ctl #(
   parameter int unsigned PDL_AW = 10
) (
   input  logic            clk,
   input  logic            reset_n,
   pdl_ptr_ctl_if.slave    bus
);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t            state_q, state_d;
   logic [PDL_AW-1:0] ptr_q, ptr_d;
   logic [PDL_AW-1:0] idx_q, idx_d;
   logic [PDL_AW-1:0] wa_q, wa_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              commit;
   logic              wr_req;
   logic [PDL_AW-1:0] ob_addr;
   logic [PDL_AW-1:0] ptr_inc;
   logic [PDL_AW-1:0] ptr_dec;
   logic              unused_ob;

   assign commit    = bus.state_write & ~bus.nop;
   assign wr_req    = bus.destpdltop | bus.destpdl_p | bus.destpdl_x;
   assign ob_addr   = bus.ob[PDL_AW-1:0];
   assign ptr_inc   = ptr_q + PDL_AW'(1);
   assign ptr_dec   = ptr_q - PDL_AW'(1);
   assign unused_ob = ^bus.ob[31:PDL_AW];

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         wa_q    <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         wa_q    <= wa_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Next-state: pointer/index/flag update and write-address capture on commit
   always_comb begin
      state_d = IDLE;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      wa_d    = wa_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      if (commit) begin
         // Explicit pointer load overrides any push/pop in the same instruction
         if (bus.destpdlp) begin
            ptr_d = ob_addr;
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end else if (bus.destpdl_p && bus.srcpdlpop) begin
            ptr_d = ptr_q;
         end else if (bus.destpdl_p) begin
            ptr_d = ptr_inc;
            if (ptr_q == '1) ovf_d = 1'b1;
         end else if (bus.srcpdlpop) begin
            ptr_d = ptr_dec;
            if (ptr_q == '0) unf_d = 1'b1;
         end

         if (bus.destpdlx) idx_d = ob_addr;

         // Write address is taken from pre-commit register values
         if (wr_req) begin
            state_d = WRITE;
            if (bus.destpdl_x)      wa_d = idx_q;
            else if (bus.destpdl_p) wa_d = bus.srcpdlpop ? ptr_q : ptr_inc;
            else                    wa_d = ptr_q;
         end
      end
   end

   assign bus.pdlptr    = ptr_q;
   assign bus.pdlidx    = idx_q;
   assign bus.pdlwa     = wa_q;
   assign bus.pdlovf    = ovf_q;
   assign bus.pdlunf    = unf_q;
   assign bus.pdlwe     = (state_q == WRITE);
   assign bus.pdlra     = bus.srcpdltop ? idx_q : ptr_q;
   assign bus.pdlbypass = bus.pdlwe & (bus.pdlra == wa_q);

endmodule

// File: tb/tb_pdl_ptr_ctl.sv
// Purpose: self-checking bench for pdl_ptr_ctl; directed scenarios followed by
//          random instruction streams checked against an arithmetic model.
module tb_pdl_ptr_ctl;

   localparam int unsigned AW   = 10;
   localparam int unsigned SIZE = 1 << AW;

   localparam logic [8:0] SW   = 9'h001;
   localparam logic [8:0] NOP  = 9'h002;
   localparam logic [8:0] DP   = 9'h004;
   localparam logic [8:0] DX   = 9'h008;
   localparam logic [8:0] DTOP = 9'h010;
   localparam logic [8:0] DPP  = 9'h020;
   localparam logic [8:0] DPX  = 9'h040;
   localparam logic [8:0] STOP = 9'h080;
   localparam logic [8:0] SPOP = 9'h100;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_pass;
   int   n_fail;

   // reference model state
   int m_ptr, m_idx, m_wa;
   bit m_we, m_ovf, m_unf;

   pdl_ptr_ctl_if #(.PDL_AW(AW)) bus ();

   pdl_ptr_ctl #(.PDL_AW(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [8:0] s, input logic [31:0] ob_i);
      bus.state_write = s[0];
      bus.nop         = s[1];
      bus.destpdlp    = s[2];
      bus.destpdlx    = s[3];
      bus.destpdltop  = s[4];
      bus.destpdl_p   = s[5];
      bus.destpdl_x   = s[6];
      bus.srcpdltop   = s[7];
      bus.srcpdlpop   = s[8];
      bus.ob          = ob_i;
   endtask

   function automatic void model_reset();
      m_ptr = 0; m_idx = 0; m_wa = 0;
      m_we = 0; m_ovf = 0; m_unf = 0;
   endfunction

   // Clock-edge behaviour written from the instruction semantics
   function automatic void model_edge(input logic [8:0] s, input logic [31:0] ob_i);
      int  o;
      int  old_ptr;
      int  old_idx;
      bit  wr;
      old_ptr = m_ptr;
      old_idx = m_idx;
      o  = int'(ob_i % SIZE);
      wr = (s & (DTOP | DPP | DPX)) != 0;
      m_we = 0;
      if ((s & SW) != 0 && (s & NOP) == 0) begin
         if ((s & DP) != 0) begin
            m_ptr = o; m_ovf = 0; m_unf = 0;
         end else if ((s & DPP) != 0 && (s & SPOP) != 0) begin
            m_ptr = old_ptr;
         end else if ((s & DPP) != 0) begin
            if (old_ptr == SIZE - 1) m_ovf = 1;
            m_ptr = (old_ptr + 1) % SIZE;
         end else if ((s & SPOP) != 0) begin
            if (old_ptr == 0) m_unf = 1;
            m_ptr = (old_ptr + SIZE - 1) % SIZE;
         end
         if ((s & DX) != 0) m_idx = o;
         if (wr) begin
            m_we = 1;
            if ((s & DPX) != 0)      m_wa = old_idx;
            else if ((s & DPP) != 0) m_wa = ((s & SPOP) != 0) ? old_ptr : (old_ptr + 1) % SIZE;
            else                     m_wa = old_ptr;
         end
      end
   endfunction

   // One instruction: drive, check combinational read side, clock, check registers
   task automatic step(input logic [8:0] s, input logic [31:0] ob_i);
      int ra;
      drive(s, ob_i);
      #1;
      ra = ((s & STOP) != 0) ? m_idx : m_ptr;
      check("pdlra",     32'(bus.pdlra), 32'(ra));
      check("pdlbypass", 32'(bus.pdlbypass), 32'(m_we && (ra == m_wa)));
      @(posedge clk);
      model_edge(s, ob_i);
      #1;
      check("pdlptr", 32'(bus.pdlptr), 32'(m_ptr));
      check("pdlidx", 32'(bus.pdlidx), 32'(m_idx));
      check("pdlwa",  32'(bus.pdlwa),  32'(m_wa));
      check("pdlwe",  32'(bus.pdlwe),  32'(m_we));
      check("pdlovf", 32'(bus.pdlovf), 32'(m_ovf));
      check("pdlunf", 32'(bus.pdlunf), 32'(m_unf));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ptr"}, 32'(bus.pdlptr), 32'd0);
      check({tag, "_idx"}, 32'(bus.pdlidx), 32'd0);
      check({tag, "_wa"},  32'(bus.pdlwa),  32'd0);
      check({tag, "_we"},  32'(bus.pdlwe),  32'd0);
      check({tag, "_ovf"}, 32'(bus.pdlovf), 32'd0);
      check({tag, "_unf"}, 32'(bus.pdlunf), 32'd0);
      check({tag, "_byp"}, 32'(bus.pdlbypass), 32'd0);
   endtask

   initial begin
      logic [8:0]  s;
      logic [31:0] ob_r;
      n_checks = 0; n_pass = 0; n_fail = 0;
      model_reset();

      // Reset held while strobes are active
      reset_n = 1'b0;
      drive(SW | DP | DPP | DX, 32'h0000_0155);
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst");
      drive(9'h000, 32'h0);
      reset_n = 1'b1;

      // Load then two pushes wrapping max->0
      step(SW | DP, 32'h0000_03FE);
      step(SW | DPP, 32'h0);
      check("push1_ptr", 32'(bus.pdlptr), 32'h3FF);
      check("push1_wa",  32'(bus.pdlwa),  32'h3FF);
      step(SW | DPP, 32'h0);
      check("push2_ptr", 32'(bus.pdlptr), 32'h000);
      check("push2_ovf", 32'(bus.pdlovf), 32'd1);
      step(9'h000, 32'h0);

      // Pop from 0 underflows, then reload clears flags
      step(SW | SPOP, 32'h0);
      check("pop_ptr", 32'(bus.pdlptr), 32'h3FF);
      check("pop_unf", 32'(bus.pdlunf), 32'd1);
      step(SW | DP, 32'h0000_0005);
      check("reload_unf", 32'(bus.pdlunf), 32'd0);
      check("reload_ovf", 32'(bus.pdlovf), 32'd0);

      // Push+pop together leaves pointer and writes at it
      step(SW | DP, 32'h0000_0007);
      step(SW | DPP | SPOP, 32'h0);
      check("pp_ptr", 32'(bus.pdlptr), 32'h007);
      check("pp_wa",  32'(bus.pdlwa),  32'h007);
      check("pp_we",  32'(bus.pdlwe),  32'd1);

      // Index write then read of same slot during write clk
      step(SW | DX, 32'hFFFF_FC12);
      step(SW | DPX, 32'h0);
      check("idx_wa", 32'(bus.pdlwa), 32'h012);
      drive(STOP, 32'h0);
      #1;
      check("idx_ra",  32'(bus.pdlra), 32'h012);
      check("idx_byp", 32'(bus.pdlbypass), 32'd1);
      step(STOP, 32'h0);

      // Gating: suppressed or non-final phase does nothing
      step(SW | NOP | DPP | DP, 32'h0000_0100);
      step(DPP | DP | DX, 32'h0000_0200);
      check("gate_ptr", 32'(bus.pdlptr), 32'h007);
      check("gate_we",  32'(bus.pdlwe),  32'd0);

      // Back-to-back writes, then async reset during pdlwe
      step(SW | DTOP, 32'h0);
      step(SW | DPP | DX, 32'h0000_0033);
      check("b2b_we", 32'(bus.pdlwe), 32'd1);
      check("b2b_wa", 32'(bus.pdlwa), 32'h008);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all_zero("arst");
      drive(9'h000, 32'h0);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Random instruction stream
      for (int i = 0; i < 400; i++) begin
         s = 9'h000;
         if ($urandom_range(0, 3) != 0) s |= SW;
         if ($urandom_range(0, 7) == 0) s |= NOP;
         if ($urandom_range(0, 5) == 0) s |= DP;
         if ($urandom_range(0, 4) == 0) s |= DX;
         case ($urandom_range(0, 3))
            0: s |= DTOP;
            1: s |= DPP;
            2: s |= DPX;
            default: ;
         endcase
         if ($urandom_range(0, 2) == 0) s |= STOP;
         if ($urandom_range(0, 2) == 0) s |= SPOP;
         ob_r = $urandom;
         // bias pointer loads toward the wrap boundaries
         if ($urandom_range(0, 3) == 0) ob_r[AW-1:0] = ($urandom_range(0, 1) != 0) ? '1 : '0;
         step(s, ob_r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
